// File: rtl/hpi_pkg.sv
// hpi_pkg: shared types and constants for the HPI burst engine.
//   hpi_state_t : engine FSM states
//   HPI_*       : CY7C67200 HPI register-select codes driven on otg_hpi_address
//   hpi_max3    : constant helper used to size the shared phase counter
package hpi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SETUP,
      STROBE,
      HOLD
   } hpi_state_t;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   function automatic int hpi_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/hpi_burst_master_if.sv
// hpi_burst_master_if: command, write-data, read-data and HPI pin bundle.
//   cmd_*          : burst command valid/ready (write, addr, len = beats-1)
//   wr_data_*      : write beat handshake and data
//   rd_data_*      : read FIFO head handshake and data
//   otg_hpi_*      : HPI pins (address, cs_n, r_n, w_n, data out/oe/in)
// Modports: master = the burst engine, slave = SoC fabric plus pin side.
interface hpi_burst_master_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2,
   parameter int LEN_W  = 4
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wr_data_valid;
   logic              wr_data_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_data_valid;
   logic              rd_data_ready;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] otg_hpi_address;
   logic              otg_hpi_cs_n;
   logic              otg_hpi_r_n;
   logic              otg_hpi_w_n;
   logic [DATA_W-1:0] otg_hpi_data_out;
   logic              otg_hpi_data_oe;
   logic [DATA_W-1:0] otg_hpi_data_in;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  wr_data_valid, wr_data, rd_data_ready, otg_hpi_data_in,
      output cmd_ready, wr_data_ready, rd_data_valid, rd_data,
      output otg_hpi_address, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
      output otg_hpi_data_out, otg_hpi_data_oe
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output wr_data_valid, wr_data, rd_data_ready, otg_hpi_data_in,
      input  cmd_ready, wr_data_ready, rd_data_valid, rd_data,
      input  otg_hpi_address, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
      input  otg_hpi_data_out, otg_hpi_data_oe
   );
endinterface

// File: rtl/hpi_rd_fifo.sv
// hpi_rd_fifo: synchronous read-data FIFO, flop storage, head read from storage.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write one entry (caller guarantees not full)
//   pop, pop_data   : remove head (caller guarantees not empty); pop_data = head
//   count/full/empty: occupancy status; push+pop together keeps count
module hpi_rd_fifo #(
   parameter int DATA_W   = 16,
   parameter int RD_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [DATA_W-1:0]         push_data,
   input  logic                      pop,
   output logic [DATA_W-1:0]         pop_data,
   output logic [$clog2(RD_DEPTH):0] count,
   output logic                      full,
   output logic                      empty
);
   localparam int AW = $clog2(RD_DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [RD_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign full     = (count_q == CW'(RD_DEPTH));
   assign empty    = (count_q == '0);
endmodule

// File: rtl/hpi_burst_master.sv
// hpi_burst_master: CY7C67200 HPI burst transaction engine.
//   clk_clk, reset_reset : clock, synchronous active-high reset
//   bus (master)         : command / write data / read FIFO / HPI pins
//   busy                 : burst in progress
//   stat_beats, stat_stall (only with HPI_STATS_EN defined): completed beats
//                          and WAIT stall cycles, saturating
// Optional build macro: HPI_STATS_EN.
//
// state  | meaning
// IDLE   | cmd_ready, pins idle
// WAIT   | beat start: wait for write data or read FIFO space, pins idle
// SETUP  | address + cs_n low, SETUP_CYC cycles
// STROBE | r_n or w_n low, STROBE_CYC cycles; read sampled at its last edge
// HOLD   | cs_n low, strobes high, HOLD_CYC cycles
module hpi_burst_master
   import hpi_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 2,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int MAX_BURST  = 16,
   parameter int RD_DEPTH   = 8
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   hpi_burst_master_if.master bus,
   output logic               busy
`ifdef HPI_STATS_EN
   ,
   output logic [31:0]        stat_beats,
   output logic [31:0]        stat_stall
`endif
);
   localparam int LEN_W = $clog2(MAX_BURST);
   localparam int PH_W  = $clog2(hpi_max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
   localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYC - 1);
   localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYC - 1);
   localparam logic [PH_W-1:0] HOLD_LD   = PH_W'(HOLD_CYC - 1);
   localparam int CNT_W = $clog2(RD_DEPTH) + 1;

   hpi_state_t        state_q, state_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic [LEN_W-1:0]  beat_q, beat_d, len_q, len_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              cs_n_q, r_n_q, w_n_q, oe_q;
   logic              push_req, beat_done, stall, active_d;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      beat_d    = beat_q;
      len_d     = len_q;
      write_d   = write_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      push_req  = 1'b0;
      beat_done = 1'b0;
      stall     = 1'b0;
      bus.wr_data_ready = 1'b0;
      case (state_q)
         IDLE: if (bus.cmd_valid) begin
            write_d = bus.cmd_write;
            addr_d  = bus.cmd_addr;
            len_d   = bus.cmd_len;
            beat_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (write_q ? bus.wr_data_valid : (fifo_count < CNT_W'(RD_DEPTH))) begin
               bus.wr_data_ready = write_q;
               if (write_q) dout_d = bus.wr_data;
               state_d = SETUP;
               ph_d    = SETUP_LD;
            end else begin
               stall = 1'b1;
            end
         end
         SETUP: if (ph_q == '0) begin
            state_d = STROBE;
            ph_d    = STROBE_LD;
         end else ph_d = ph_q - PH_W'(1);
         STROBE: if (ph_q == '0) begin
            push_req = ~write_q;
            state_d  = HOLD;
            ph_d     = HOLD_LD;
         end else ph_d = ph_q - PH_W'(1);
         HOLD: if (ph_q == '0) begin
            beat_done = 1'b1;
            if (beat_q == len_q) state_d = IDLE;
            else begin
               beat_d  = beat_q + LEN_W'(1);
               state_d = WAIT;
            end
         end else ph_d = ph_q - PH_W'(1);
         default: state_d = IDLE;
      endcase
      active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
   end

   // Pins are registered from the next-state decode so they switch cleanly on
   // the edge that enters each phase.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= IDLE;
         ph_q    <= '0;
         beat_q  <= '0;
         len_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
         cs_n_q  <= 1'b1;
         r_n_q   <= 1'b1;
         w_n_q   <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         cs_n_q  <= ~active_d;
         r_n_q   <= ~((state_d == STROBE) && !write_d);
         w_n_q   <= ~((state_d == STROBE) && write_d);
         oe_q    <= active_d && write_d;
      end
   end

   // Space is reserved at beat start, so the full guard never blocks a push.
   hpi_rd_fifo #(.DATA_W(DATA_W), .RD_DEPTH(RD_DEPTH)) u_rd_fifo (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .push      (push_req & ~fifo_full),
      .push_data (bus.otg_hpi_data_in),
      .pop       (bus.rd_data_ready & ~fifo_empty),
      .pop_data  (bus.rd_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.cmd_ready        = (state_q == IDLE) && !reset_reset;
   assign bus.rd_data_valid    = ~fifo_empty;
   assign bus.otg_hpi_address  = addr_q;
   assign bus.otg_hpi_cs_n     = cs_n_q;
   assign bus.otg_hpi_r_n      = r_n_q;
   assign bus.otg_hpi_w_n      = w_n_q;
   assign bus.otg_hpi_data_out = dout_q;
   assign bus.otg_hpi_data_oe  = oe_q;
   assign busy                 = (state_q != IDLE);

`ifdef HPI_STATS_EN
   logic [31:0] beats_q, stall_q;
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         beats_q <= '0;
         stall_q <= '0;
      end else begin
         if (beat_done && (beats_q != '1)) beats_q <= beats_q + 32'd1;
         if (stall && (stall_q != '1))     stall_q <= stall_q + 32'd1;
      end
   end
   assign stat_beats = beats_q;
   assign stat_stall = stall_q;
`endif
endmodule

// File: tb/tb_hpi_burst_master.sv
module tb_hpi_burst_master;
   import hpi_pkg::*;

   logic clk_clk = 1'b0;
   logic reset_reset = 1'b1;
   logic busy;
`ifdef HPI_STATS_EN
   logic [31:0] stat_beats, stat_stall;
`endif

   hpi_burst_master_if #(.DATA_W(16), .ADDR_W(2), .LEN_W(4)) bus();

   hpi_burst_master #(
      .DATA_W(16), .ADDR_W(2), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1),
      .MAX_BURST(16), .RD_DEPTH(8)
   ) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .bus         (bus),
      .busy        (busy)
`ifdef HPI_STATS_EN
      ,
      .stat_beats  (stat_beats),
      .stat_stall  (stat_stall)
`endif
   );

   always #5 clk_clk = ~clk_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Scoreboards: read data expected from the FIFO, write data expected on pins.
   logic [15:0] rexp_q[$];
   logic [15:0] wexp_q[$];
   logic [1:0]  exp_addr  = 2'd0;
   logic        exp_write = 1'b0;

   // Pin model: each read beat returns pin_base + beat index.
   logic [15:0] pin_base = 16'h0;
   int          pin_cnt  = 0;
   logic        pin_prev_rn = 1'b1;
   assign bus.otg_hpi_data_in = pin_base + 16'(pin_cnt);
   always @(negedge clk_clk) begin
      if (bus.otg_hpi_r_n && !pin_prev_rn) pin_cnt++;
      pin_prev_rn = bus.otg_hpi_r_n;
   end

   // Pin / FIFO monitor.
   int   cs_run = 0, st_run = 0, wr_beats = 0, rd_beats = 0, wait_cnt = 0;
   logic prev_cs = 1'b1, prev_rn = 1'b1, prev_wn = 1'b1;
   always @(negedge clk_clk) begin
      if (reset_reset) begin
         cs_run = 0; st_run = 0;
         prev_cs = 1'b1; prev_rn = 1'b1; prev_wn = 1'b1;
      end else begin
         if (bus.rd_data_valid && bus.rd_data_ready) begin
            if (rexp_q.size() == 0) fail_now("rd_unexpected_pop");
            else chk("rd_data", 32'(bus.rd_data), 32'(rexp_q.pop_front()));
         end
         if (!bus.otg_hpi_w_n && prev_wn) begin
            if (wexp_q.size() == 0) fail_now("wr_unexpected_beat");
            else chk("wr_pin_data", 32'(bus.otg_hpi_data_out), 32'(wexp_q.pop_front()));
            chk("wr_addr", 32'(bus.otg_hpi_address), 32'(exp_addr));
            wr_beats++;
         end
         if (!bus.otg_hpi_r_n && prev_rn) begin
            chk("rd_addr", 32'(bus.otg_hpi_address), 32'(exp_addr));
            rd_beats++;
         end
         if (!bus.otg_hpi_cs_n) begin
            cs_run++;
            if (!bus.otg_hpi_r_n || !bus.otg_hpi_w_n) st_run++;
            chk("oe_during_cs", 32'(bus.otg_hpi_data_oe), 32'(exp_write));
            chk("other_strobe_high", 32'(exp_write ? bus.otg_hpi_r_n : bus.otg_hpi_w_n), 32'd1);
         end
         if (bus.otg_hpi_cs_n && !prev_cs) begin
            chk("cs_low_width", 32'(cs_run), 32'd4);
            chk("strobe_width", 32'(st_run), 32'd2);
            cs_run = 0; st_run = 0;
         end
         if (busy && bus.otg_hpi_cs_n) wait_cnt++;
         prev_cs = bus.otg_hpi_cs_n;
         prev_rn = bus.otg_hpi_r_n;
         prev_wn = bus.otg_hpi_w_n;
      end
   end

   task automatic send_cmd(input logic w, input logic [1:0] a, input logic [3:0] l,
                           input logic [15:0] base);
      int n;
      exp_addr  = a;
      exp_write = w;
      if (!w) begin
         pin_base = base;
         pin_cnt  = 0;
         for (int i = 0; i <= int'(l); i++) rexp_q.push_back(base + 16'(i));
      end
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      bus.cmd_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk_clk);
         n++;
      end while (!bus.cmd_ready && n < 20);
      if (!bus.cmd_ready) fail_now("cmd_accept_timeout");
      @(posedge clk_clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int cyc, output int first_cs,
                            output logic busy1);
      cyc = 0; first_cs = -1; busy1 = 1'b0;
      while (cyc < budget) begin
         @(negedge clk_clk);
         cyc++;
         if (cyc == 1) busy1 = busy;
         if (first_cs < 0 && !bus.otg_hpi_cs_n) first_cs = cyc;
         if (bus.cmd_ready) break;
      end
      if (!bus.cmd_ready) fail_now("idle_timeout");
   endtask

   // Write data source; before stall_beat the valid line is dropped for gap cycles.
   task automatic wr_source(input int beats, input logic [15:0] base,
                            input int stall_beat, input int gap);
      int n;
      for (int b = 0; b < beats; b++) begin
         if (b == stall_beat) begin
            bus.wr_data_valid = 1'b0;
            repeat (gap) @(posedge clk_clk);
            #1;
         end
         bus.wr_data       = base + 16'(b);
         bus.wr_data_valid = 1'b1;
         wexp_q.push_back(base + 16'(b));
         n = 0;
         do begin
            @(negedge clk_clk);
            n++;
         end while (!bus.wr_data_ready && n < 200);
         if (!bus.wr_data_ready) begin
            fail_now("wr_handshake_timeout");
            break;
         end
         @(posedge clk_clk);
         #1;
      end
      bus.wr_data_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk_clk);
      #1 reset_reset = 1'b1;
      @(posedge clk_clk);
      #1 reset_reset = 1'b0;
      rexp_q.delete();
      wexp_q.delete();
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [3:0]  len;
      logic [15:0] base;
      int          exp_cycles;
      int          exp_first_cs;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog_timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   cyc, fcs, wb0, rb0, n;
      logic b1;

      vecs[0] = '{1'b1, HPI_ADDRESS, 4'd0,  16'h1000, 6,  2};
      vecs[1] = '{1'b0, HPI_DATA,    4'd3,  16'h00A0, 21, 2};
      vecs[2] = '{1'b1, HPI_MAILBOX, 4'd1,  16'h55AA, 11, 2};
      vecs[3] = '{1'b0, HPI_STATUS,  4'd15, 16'h0300, 81, 2};
      vecs[4] = '{1'b1, HPI_DATA,    4'd15, 16'h2000, 81, 2};

      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
      bus.wr_data_valid = 1'b0; bus.wr_data = '0; bus.rd_data_ready = 1'b0;

      // Reset values
      repeat (3) @(posedge clk_clk);
      @(negedge clk_clk);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_cs_n", 32'(bus.otg_hpi_cs_n), 32'd1);
      chk("rst_r_n", 32'(bus.otg_hpi_r_n), 32'd1);
      chk("rst_w_n", 32'(bus.otg_hpi_w_n), 32'd1);
      chk("rst_oe", 32'(bus.otg_hpi_data_oe), 32'd0);
      chk("rst_addr", 32'(bus.otg_hpi_address), 32'd0);
      chk("rst_data_out", 32'(bus.otg_hpi_data_out), 32'd0);
      chk("rst_wr_ready", 32'(bus.wr_data_ready), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_data_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk_clk);
      #1 reset_reset = 1'b0;
      @(negedge clk_clk);
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // Table-driven unstalled bursts
      bus.rd_data_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_clk);
         #1;
         wb0 = wr_beats; rb0 = rd_beats;
         if (vecs[i].wr) begin
            fork
               begin
                  send_cmd(1'b1, vecs[i].addr, vecs[i].len, vecs[i].base);
                  wait_idle(200, cyc, fcs, b1);
               end
               wr_source(int'(vecs[i].len) + 1, vecs[i].base, -1, 0);
            join
         end else begin
            send_cmd(1'b0, vecs[i].addr, vecs[i].len, vecs[i].base);
            wait_idle(200, cyc, fcs, b1);
         end
         chk("accept_to_ready", 32'(cyc), 32'(vecs[i].exp_cycles));
         chk("accept_to_cs_low", 32'(fcs), 32'(vecs[i].exp_first_cs));
         chk("busy_after_accept", 32'(b1), 32'd1);
         chk("beat_count", 32'(vecs[i].wr ? wr_beats - wb0 : rd_beats - rb0),
             32'(int'(vecs[i].len) + 1));
         repeat (3) @(posedge clk_clk);
         #1;
         chk("rd_scoreboard_drained", 32'(rexp_q.size()), 32'd0);
         chk("wr_scoreboard_drained", 32'(wexp_q.size()), 32'd0);
      end

      // Read back-pressure: FIFO fills after 8 beats, then engine stalls in WAIT
      bus.rd_data_ready = 1'b0;
      rb0 = rd_beats;
      send_cmd(1'b0, HPI_DATA, 4'd15, 16'h00C0);
      repeat (60) @(negedge clk_clk);
      chk("bp_beats_before_release", 32'(rd_beats - rb0), 32'd8);
      chk("bp_cs_n_high", 32'(bus.otg_hpi_cs_n), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_rd_valid", 32'(bus.rd_data_valid), 32'd1);
      @(posedge clk_clk);
      #1 bus.rd_data_ready = 1'b1;
      wait_idle(300, cyc, fcs, b1);
      repeat (12) @(posedge clk_clk);
      #1;
      chk("bp_total_beats", 32'(rd_beats - rb0), 32'd16);
      chk("bp_all_data_popped", 32'(rexp_q.size()), 32'd0);
      chk("bp_fifo_empty", 32'(bus.rd_data_valid), 32'd0);

      // Write with a 3-cycle data gap before the second beat
      do_reset();
      wait_cnt = 0;
      wb0 = wr_beats;
      fork
         begin
            send_cmd(1'b1, HPI_MAILBOX, 4'd2, 16'h0);
            wait_idle(200, cyc, fcs, b1);
         end
         wr_source(3, 16'h3000, 1, 4 + 3);
      join
      chk("gap_beats", 32'(wr_beats - wb0), 32'd3);
      chk("gap_accept_to_ready", 32'(cyc), 32'd19);
      chk("gap_wait_cycles_cs_high", 32'(wait_cnt), 32'd6);
`ifdef HPI_STATS_EN
      chk("stat_beats", stat_beats, 32'd3);
      chk("stat_stall", stat_stall, 32'd3);
`endif

      // Reset in the middle of a read strobe
      @(posedge clk_clk);
      #1 bus.rd_data_ready = 1'b0;
      rb0 = rd_beats;
      send_cmd(1'b0, HPI_DATA, 4'd3, 16'h0050);
      n = 0;
      while (rd_beats - rb0 < 2 && n < 50) begin
         @(negedge clk_clk);
         n++;
      end
      if (rd_beats - rb0 < 2) fail_now("midstrobe_wait_timeout");
      chk("pre_reset_r_n_low", 32'(bus.otg_hpi_r_n), 32'd0);
      @(posedge clk_clk);
      #1 reset_reset = 1'b1;
      @(posedge clk_clk);
      #1;
      chk("mid_rst_r_n", 32'(bus.otg_hpi_r_n), 32'd1);
      chk("mid_rst_cs_n", 32'(bus.otg_hpi_cs_n), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rd_valid", 32'(bus.rd_data_valid), 32'd0);
      chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      reset_reset = 1'b0;
      rexp_q.delete();
      @(negedge clk_clk);
      chk("after_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      bus.rd_data_ready = 1'b1;
      rb0 = rd_beats;
      @(posedge clk_clk);
      #1;
      send_cmd(1'b0, HPI_MAILBOX, 4'd1, 16'h0070);
      wait_idle(100, cyc, fcs, b1);
      chk("fresh_accept_to_ready", 32'(cyc), 32'd11);
      repeat (3) @(posedge clk_clk);
      #1;
      chk("fresh_beats", 32'(rd_beats - rb0), 32'd2);
      chk("fresh_data_drained", 32'(rexp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
